// File: rtl/ibexc_trace_pkg.sv
// ibexc_trace_pkg: record layout, beat numbering and beat-2 field positions for the RVFI trace buffer (rev 1.0).
// Optional timestamp beat is enabled by defining IBEXC_TRACE_TIMESTAMP_EN.
`default_nettype none

package ibexc_trace_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
    logic        trap;
    logic        intr;
    logic        lost;
    logic [4:0]  rd_addr;
    logic [3:0]  rmask;
    logic [3:0]  wmask;
    logic [15:0] order;
    logic [31:0] rd_wdata;
    logic [31:0] mem_addr;
`ifdef IBEXC_TRACE_TIMESTAMP_EN
    logic [31:0] ts;
`endif
  } trc_rec_t;

  localparam int unsigned REC_W = $bits(trc_rec_t);

`ifdef IBEXC_TRACE_TIMESTAMP_EN
  localparam int unsigned NB = 6;
`else
  localparam int unsigned NB = 5;
`endif

  localparam logic [2:0] BEAT_PC    = 3'd0;
  localparam logic [2:0] BEAT_INSN  = 3'd1;
  localparam logic [2:0] BEAT_INFO  = 3'd2;
  localparam logic [2:0] BEAT_WDATA = 3'd3;
  localparam logic [2:0] BEAT_MADDR = 3'd4;
  localparam logic [2:0] BEAT_TS    = 3'd5;
  localparam logic [2:0] BEAT_LAST  = 3'(NB - 1);

  localparam int unsigned B2_TRAP      = 31;
  localparam int unsigned B2_INTR      = 30;
  localparam int unsigned B2_LOST      = 29;
  localparam int unsigned B2_RD_LSB    = 24;
  localparam int unsigned B2_RMASK_LSB = 20;
  localparam int unsigned B2_WMASK_LSB = 16;
  localparam int unsigned B2_ORDER_LSB = 0;

  function automatic logic [31:0] beat2_word(trc_rec_t r);
    logic [31:0] w;
    w = '0;
    w[B2_TRAP]               = r.trap;
    w[B2_INTR]               = r.intr;
    w[B2_LOST]               = r.lost;
    w[B2_RD_LSB +: 5]        = r.rd_addr;
    w[B2_RMASK_LSB +: 4]     = r.rmask;
    w[B2_WMASK_LSB +: 4]     = r.wmask;
    w[B2_ORDER_LSB +: 16]    = r.order;
    return w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ibexc_trace_fifo.sv
// ibexc_trace_fifo: record FIFO with wrap-bit pointers (count = wptr - rptr), rev 1.0.
// Caller must not push when full nor pop when empty.
`default_nettype none

module ibexc_trace_fifo #(
  parameter int unsigned Width = 160,
  parameter int unsigned Depth = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [Width-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [Width-1:0]         rdata_o,
  output logic [$clog2(Depth):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int unsigned AW = $clog2(Depth);

  logic [AW:0]      wptr_q;
  logic [AW:0]      rptr_q;
  logic [Width-1:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push_i) wptr_q <= wptr_q + 1'b1;
      if (pop_i)  rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end

  assign rdata_o = mem_q[rptr_q[AW-1:0]];
  assign count_o = wptr_q - rptr_q;
  assign full_o  = (count_o == (AW+1)'(Depth));
  assign empty_o = (count_o == '0);

endmodule

`default_nettype wire

// File: rtl/ibexc_trace_buf.sv
// ibexc_trace_buf: captures RVFI retirements into a record FIFO and streams each record as 32-bit beats (rev 1.0).
// Define IBEXC_TRACE_TIMESTAMP_EN to append a free-running cycle timestamp as a sixth beat.
`default_nettype none

module ibexc_trace_buf
  import ibexc_trace_pkg::*;
#(
  parameter int unsigned Depth = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        trc_en_i,
  input  logic        rvfi_valid,
  input  logic [63:0] rvfi_order,
  input  logic [31:0] rvfi_pc_rdata,
  input  logic [31:0] rvfi_insn,
  input  logic        rvfi_trap,
  input  logic        rvfi_intr,
  input  logic [4:0]  rvfi_rd_addr,
  input  logic [31:0] rvfi_rd_wdata,
  input  logic [31:0] rvfi_mem_addr,
  input  logic [3:0]  rvfi_mem_rmask,
  input  logic [3:0]  rvfi_mem_wmask,
  output logic        trc_valid_o,
  input  logic        trc_ready_i,
  output logic [31:0] trc_data_o,
  output logic        trc_last_o,
  output logic [15:0] trc_drop_cnt_o
);

  localparam int unsigned CW = $clog2(Depth) + 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic             lost_q, lost_d;
  logic [15:0]      drop_cnt_q, drop_cnt_d;

  logic [CW-1:0]    fifo_cnt;
  logic             fifo_full, fifo_empty;
  logic [REC_W-1:0] fifo_wdata, fifo_rdata;
  trc_rec_t         wrec, rrec;
  logic             capture, push, drop, xfer, last_beat, pop;
  logic [31:0]      beat;
  logic             unused_order;

  assign unused_order = ^rvfi_order[63:16];

`ifdef IBEXC_TRACE_TIMESTAMP_EN
  logic [31:0] ts_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) ts_q <= '0;
    else       ts_q <= ts_q + 32'd1;
  end
`endif

  // Full is judged on the registered count, so a same-cycle pop never rescues a retire.
  assign capture = rvfi_valid & trc_en_i;
  assign push    = capture & ~fifo_full;
  assign drop    = capture & fifo_full;

  always_comb begin
    wrec          = '0;
    wrec.pc       = rvfi_pc_rdata;
    wrec.insn     = rvfi_insn;
    wrec.trap     = rvfi_trap;
    wrec.intr     = rvfi_intr;
    wrec.lost     = lost_q;
    wrec.rd_addr  = rvfi_rd_addr;
    wrec.rmask    = rvfi_mem_rmask;
    wrec.wmask    = rvfi_mem_wmask;
    wrec.order    = rvfi_order[15:0];
    wrec.rd_wdata = rvfi_rd_wdata;
    wrec.mem_addr = rvfi_mem_addr;
`ifdef IBEXC_TRACE_TIMESTAMP_EN
    wrec.ts       = ts_q;
`endif
  end

  assign fifo_wdata = wrec;
  assign rrec       = trc_rec_t'(fifo_rdata);

  ibexc_trace_fifo #(
    .Width (REC_W),
    .Depth (Depth)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .wdata_i (fifo_wdata),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .count_o (fifo_cnt),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign trc_valid_o = ~rst_i & (state_q == ST_SEND);
  assign xfer        = trc_valid_o & trc_ready_i;
  assign last_beat   = (idx_q == BEAT_LAST);
  assign pop         = xfer & last_beat;

  // Entering SEND on the push itself gives beat 0 the cycle after capture.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (push || !fifo_empty) begin
          state_d = ST_SEND;
          idx_d   = '0;
        end
      end
      ST_SEND: begin
        if (xfer) begin
          if (last_beat) begin
            idx_d = '0;
            if (fifo_cnt == CW'(1) && !push) state_d = ST_IDLE;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_comb begin
    lost_d     = lost_q;
    drop_cnt_d = drop_cnt_q;
    if (drop) begin
      lost_d = 1'b1;
      if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
    end else if (push) begin
      lost_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      lost_q     <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      lost_q     <= lost_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  always_comb begin
    beat = '0;
    case (idx_q)
      BEAT_PC:    beat = rrec.pc;
      BEAT_INSN:  beat = rrec.insn;
      BEAT_INFO:  beat = beat2_word(rrec);
      BEAT_WDATA: beat = rrec.rd_wdata;
      BEAT_MADDR: beat = rrec.mem_addr;
`ifdef IBEXC_TRACE_TIMESTAMP_EN
      BEAT_TS:    beat = rrec.ts;
`endif
      default:    beat = '0;
    endcase
  end

  assign trc_data_o     = trc_valid_o ? beat : 32'h0;
  assign trc_last_o     = trc_valid_o & last_beat;
  assign trc_drop_cnt_o = rst_i ? 16'h0 : drop_cnt_q;

endmodule

`default_nettype wire

// File: doc/ibexc_trace_buf.md
IBEXC_TRACE_BUF -- requirements
Module: ibexc_trace_buf

Interface
REQ-001 SHALL have parameter Depth, default 8, meaning record-FIFO entries (power of 2, ≥2).
REQ-002 SHALL have ports in this order:
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- trc_en_i  in  1  capture enable.
- rvfi_valid  in  1  instruction retired this cycle.
- rvfi_order  in  64  retirement order.
- rvfi_pc_rdata  in  32  PC of the retired instruction.
- rvfi_insn  in  32  instruction word.
- rvfi_trap  in  1  trap flag.
- rvfi_intr  in  1  interrupt-entry flag.
- rvfi_rd_addr  in  5  destination register.
- rvfi_rd_wdata  in  32  destination write data.
- rvfi_mem_addr  in  32  memory address.
- rvfi_mem_rmask  in  4  read byte mask.
- rvfi_mem_wmask  in  4  write byte mask.
- trc_valid_o  out  1  beat valid.
- trc_ready_i  in  1  sink accepts the beat.
- trc_data_o  out  32  beat payload.
- trc_last_o  out  1  final beat of the record.
- trc_drop_cnt_o  out  16  dropped-record count, saturating.

Function
REQ-003 SHALL capture one record on a cycle with rvfi_valid=1 and trc_en_i=1 when the FIFO is not full.
REQ-004 SHALL ignore rvfi_valid while trc_en_i=0; such cycles are not counted as drops.
REQ-005 SHALL drop the record when rvfi_valid=1, trc_en_i=1 and the registered FIFO count equals Depth; this applies even if a final beat pops in the same cycle.
REQ-006 On a drop, SHALL increment trc_drop_cnt_o, saturating at 16'hFFFF, and SHALL set a pending-lost flag.
REQ-007 SHALL write the pending-lost flag into the next captured record, then clear it in that same cycle.
REQ-008 SHALL serialize each record as 5 beats in this order:
- pc
- insn
- {trap, intr, lost, rd_addr, rmask, wmask, order[15:0]}, MSB first
- rd_wdata
- mem_addr
REQ-009 A beat SHALL transfer only on a cycle with trc_valid_o=1 and trc_ready_i=1.
REQ-010 While trc_valid_o=1 and trc_ready_i=0, trc_data_o and trc_last_o SHALL hold stable.
REQ-011 The serializer SHALL have two states:
- IDLE: moves to SEND when the FIFO is non-empty.
- SEND: beat index 0..NB-1; advances on each transfer; trc_last_o=1 when index=NB-1.
- On the last transfer: pops the FIFO, goes to IDLE if the FIFO will be empty, otherwise restarts at index 0 with no bubble.
REQ-012 A record captured in cycle N SHALL present beat 0 with trc_valid_o=1 in cycle N+1 when the FIFO was empty and the serializer was IDLE.
REQ-013 FIFO read and write pointers SHALL be log2(Depth)+1 bits and wrap modulo 2·Depth.
REQ-014 A push and a pop in the same cycle, with the FIFO not full, SHALL leave the count unchanged.

Reset
REQ-015 While rst_i=1 at a clock edge, the block SHALL empty the FIFO, enter IDLE, clear the lost flag and clear the timestamp.
REQ-016 During reset, outputs SHALL be trc_valid_o=0, trc_last_o=0, trc_data_o=0 and trc_drop_cnt_o=0.
REQ-017 Reset asserted mid-record SHALL abort the record; no partial-record resumption.

Configuration
REQ-018 With macro IBEXC_TRACE_TIMESTAMP_EN defined:
- a 32-bit free-running cycle counter runs from reset and wraps 32'hFFFFFFFF→0;
- its value in the capture cycle is stored with the record;
- it is emitted as beat 5, so NB=6 and trc_last_o marks beat 5.
REQ-019 Without IBEXC_TRACE_TIMESTAMP_EN, NB=5, there is no counter, and record storage SHALL be 160 bits.

Structure
REQ-020 The record struct, beat-count constants and beat-2 field positions SHALL live in ibexc_trace_pkg.
REQ-021 The FIFO SHALL be a sub-module ibexc_trace_fifo (parameterized width and depth); the serializer FSM is top-level.

Verification
REQ-022 Single record:
- stimulus: pc=32'h8000_0000, insn=32'h0000_0013, order=5, ready held 1, FIFO empty.
- response: beats 8000_0000, 0000_0013, 0000_0005, 0, 0 in cycles N+1..N+5; last on the fifth beat.
REQ-023 Backpressure: ready=0 for 3 cycles mid-record -> data held stable; no beat lost or duplicated.
REQ-024 Overflow:
- stimulus: Depth=8, ready=0, 10 consecutive retires.
- response: trc_drop_cnt_o=2; the record after ready returns has beat-2 bit 29=1; the first 8 records drain intact.
REQ-025 Back-to-back: 2 records with ready=1 -> 10 consecutive transfers, no idle cycle between records.
REQ-026 trc_en_i=0 during 4 retires -> nothing emitted, trc_drop_cnt_o stays 0.
REQ-027 Reset mid-record (after beat 2) -> the next cycle has trc_valid_o=0 and trc_drop_cnt_o=0. With IBEXC_TRACE_TIMESTAMP_EN, a retire 100 cycles after reset release emits beat 5=100.
